// File: rtl/nmix_mac_if.sv
// Bundle between the MAC tag sequencer, the message source, the tag sink and the nmix datapath.
// slave is the sequencer's view; master is the environment that surrounds it.
interface nmix_mac_if #(parameter int CNTW = 16);
  logic            start;
  logic [31:0]     key;
  logic [31:0]     iv;
  logic            abort;
  logic            in_valid;
  logic [31:0]     in_data;
  logic            in_last;
  logic            in_ready;
  logic [31:0]     nmix_x;
  logic [31:0]     nmix_r;
  logic            nmix_clr;
  logic [31:0]     nmix_y;
  logic [31:0]     tag;
  logic            tag_valid;
  logic            tag_ready;
  logic            busy;
  logic [CNTW-1:0] word_count;

  modport slave (
    input  start, key, iv, abort, in_valid, in_data, in_last, nmix_y, tag_ready,
    output in_ready, nmix_x, nmix_r, nmix_clr, tag, tag_valid, busy, word_count
  );
  modport master (
    output start, key, iv, abort, in_valid, in_data, in_last, nmix_y, tag_ready,
    input  in_ready, nmix_x, nmix_r, nmix_clr, tag, tag_valid, busy, word_count
  );
endinterface

// File: rtl/nmix_mac_seq.sv
// Chained MAC tag sequencer: folds each message word into the accumulator through one
// shared fixed-latency nmix instance and hands the final accumulator out as the tag.
module nmix_mac_seq #(
  parameter int LAT  = 2,
  parameter int CNTW = 16
) (
  input  logic      clk,
  input  logic      reset,
  nmix_mac_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WORD, CALC, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t          state_q, state_d;
  logic [31:0]     acc_q, acc_d, key_q, key_d, x_q, x_d, r_q, r_d, tag_q, tag_d;
  logic [CNTW-1:0] rnd_q, rnd_d, wc_q, wc_d;
  logic [3:0]      lat_q, lat_d;
  logic            last_q, last_d, in_ready_q, in_ready_d, tag_valid_q, tag_valid_d;
  logic            busy_q, busy_d, clr_q, clr_d;

  function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] t;
    t = {v, v} << n;
    return t[63:32];
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    key_d       = key_q;
    x_d         = x_q;
    r_d         = r_q;
    tag_d       = tag_q;
    rnd_d       = rnd_q;
    wc_d        = wc_q;
    lat_d       = lat_q;
    last_d      = last_q;
    in_ready_d  = in_ready_q;
    tag_valid_d = tag_valid_q;
    busy_d      = busy_q;
    clr_d       = 1'b0;
    // abort pre-empts the word handshake, the nmix capture and the tag handshake alike
    if (bus.abort && state_q != IDLE) begin
      state_d     = IDLE;
      in_ready_d  = 1'b0;
      tag_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          key_d      = bus.key;
          acc_d      = bus.iv;
          rnd_d      = '0;
          wc_d       = '0;
          clr_d      = 1'b1;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = WORD;
        end
        WORD: if (bus.in_valid && in_ready_q) begin
          x_d        = acc_q ^ bus.in_data;
          r_d        = rotl(key_q, rnd_q[4:0]);
          last_d     = bus.in_last;
          lat_d      = LAT_M1;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
        CALC: begin
          if (lat_q != 4'd0) begin
            lat_d = lat_q - 4'd1;
          end else begin
            acc_d = bus.nmix_y;
            rnd_d = rnd_q + CNTW'(1);
            wc_d  = (wc_q == '1) ? wc_q : wc_q + CNTW'(1);
            if (last_q) begin
              tag_d       = bus.nmix_y;
              tag_valid_d = 1'b1;
              state_d     = DONE;
            end else begin
              in_ready_d = 1'b1;
              state_d    = WORD;
            end
          end
        end
        DONE: if (bus.tag_ready) begin
          tag_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      key_q       <= '0;
      x_q         <= '0;
      r_q         <= '0;
      tag_q       <= '0;
      rnd_q       <= '0;
      wc_q        <= '0;
      lat_q       <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      tag_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      key_q       <= key_d;
      x_q         <= x_d;
      r_q         <= r_d;
      tag_q       <= tag_d;
      rnd_q       <= rnd_d;
      wc_q        <= wc_d;
      lat_q       <= lat_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      tag_valid_q <= tag_valid_d;
      busy_q      <= busy_d;
      clr_q       <= clr_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.nmix_x     = x_q;
  assign bus.nmix_r     = r_q;
  assign bus.nmix_clr   = clr_q;
  assign bus.tag        = tag_q;
  assign bus.tag_valid  = tag_valid_q;
  assign bus.busy       = busy_q;
  assign bus.word_count = wc_q;
endmodule

// File: tb/tb_nmix_mac_seq.sv
// Bench for nmix_mac_seq: fixed vector table, randomized messages against a fold-style
// reference model, and hand sequences for backpressure, abort and async reset.
module tb_nmix_mac_seq;
  localparam int LAT  = 2;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nmix_mac_if #(.CNTW(CNTW)) bus();
  nmix_mac_seq #(.LAT(LAT), .CNTW(CNTW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // nmix stand-in: Y = X ^ R. One register stage makes Y sampled on the LAT-th (2nd) edge
  // after X/R change reflect that X/R.
  always_ff @(posedge clk or posedge reset)
    if (reset)             bus.nmix_y <= '0;
    else if (bus.nmix_clr) bus.nmix_y <= '0;
    else                   bus.nmix_y <= bus.nmix_x ^ bus.nmix_r;

  typedef struct {
    logic [31:0] iv, key;
    int          n;
    logic [31:0] w0, w1;
    int          probe;
    logic [31:0] exp_x_probe, exp_r_probe, exp_x_last, exp_r_last, exp_tag;
    int          exp_wc;
  } vec_t;

  int n_cmp = 0, n_fail = 0;
  logic [31:0] wq[$], xq[$], rq[$], exq[$], erq[$];
  logic [31:0] mtag;
  int tot, rdy, lat_wait, clr_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rot_ref(input logic [31:0] k, input int s);
    int m;
    m = s % 32;
    if (m == 0) return k;
    return (k << m) | (k >> (32 - m));
  endfunction

  // Tag = fold of (acc ^ word) ^ rotl(key, round) over the message, as the stub nmix computes.
  task automatic model(input logic [31:0] iv, input logic [31:0] key);
    logic [31:0] acc;
    acc = iv;
    exq.delete(); erq.delete();
    foreach (wq[i]) begin
      exq.push_back(acc ^ wq[i]);
      erq.push_back(rot_ref(key, i));
      acc = exq[i] ^ erq[i];
    end
    mtag = acc;
  endtask

  // Starts a tag over wq and returns once tag_valid is seen (not yet acknowledged).
  task automatic run_msg(input logic [31:0] iv, input logic [31:0] key, input bit gaps);
    int idx, g;
    bit hs;
    xq.delete(); rq.delete();
    tot = 0; rdy = 0; lat_wait = 0; clr_cnt = 0;
    bus.key = key; bus.iv = iv; bus.start = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    idx         = 0;
    g           = 0;
    bus.in_data = wq[0];
    bus.in_last = (wq.size() == 1);
    while (idx < wq.size() && g < 5000) begin
      bus.in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      if (bus.nmix_clr) clr_cnt++;
      hs = bus.in_ready && bus.in_valid;
      tot++;
      if (bus.in_ready) rdy++;
      @(negedge clk);
      g++;
      if (hs) begin
        xq.push_back(bus.nmix_x);
        rq.push_back(bus.nmix_r);
        idx++;
        if (idx < wq.size()) begin
          bus.in_data = wq[idx];
          bus.in_last = (idx == wq.size() - 1);
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    while (!bus.tag_valid && lat_wait < 200) begin
      if (bus.nmix_clr) clr_cnt++;
      @(negedge clk);
      lat_wait++;
    end
    check("tag_valid_reached", 32'(bus.tag_valid), 32'd1);
  endtask

  task automatic ack_tag();
    bus.tag_ready = 1'b1;
    @(negedge clk);
    bus.tag_ready = 1'b0;
    check("tag_valid_after_ack", 32'(bus.tag_valid), 32'd0);
    check("busy_after_ack", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, 32'(bus.busy), 32'd0);
    check({pfx, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({pfx, "_tag_valid"}, 32'(bus.tag_valid), 32'd0);
    check({pfx, "_nmix_clr"}, 32'(bus.nmix_clr), 32'd0);
    check({pfx, "_nmix_x"}, bus.nmix_x, 32'd0);
    check({pfx, "_nmix_r"}, bus.nmix_r, 32'd0);
    check({pfx, "_tag"}, bus.tag, 32'd0);
    check({pfx, "_word_count"}, 32'(bus.word_count), 32'd0);
  endtask

  vec_t tbl[3];

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.key = 0; bus.iv = 0; bus.abort = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.tag_ready = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    tbl[0] = '{32'h0, 32'h1, 2, 32'h10, 32'h20, 0, 32'h10, 32'h1,
               32'h31, 32'h2, 32'h33, 2};
    tbl[1] = '{32'hFFFF0000, 32'h80000000, 1, 32'h0000FFFF, 32'h0, 0, 32'hFFFFFFFF, 32'h80000000,
               32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1};
    tbl[2] = '{32'h0, 32'h1, 33, 32'h0, 32'h0, 31, 32'h7FFFFFFF, 32'h80000000,
               32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 33};
    foreach (tbl[t]) begin
      wq.delete();
      for (int i = 0; i < tbl[t].n; i++) wq.push_back(i == 0 ? tbl[t].w0 : tbl[t].w1);
      run_msg(tbl[t].iv, tbl[t].key, 1'b0);
      check($sformatf("v%0d_x_probe", t), xq[tbl[t].probe], tbl[t].exp_x_probe);
      check($sformatf("v%0d_r_probe", t), rq[tbl[t].probe], tbl[t].exp_r_probe);
      check($sformatf("v%0d_x_last", t), xq[tbl[t].n-1], tbl[t].exp_x_last);
      check($sformatf("v%0d_r_last", t), rq[tbl[t].n-1], tbl[t].exp_r_last);
      check($sformatf("v%0d_tag", t), bus.tag, tbl[t].exp_tag);
      check($sformatf("v%0d_wc", t), 32'(bus.word_count), 32'(tbl[t].exp_wc));
      check($sformatf("v%0d_cycles", t), 32'(tot), 32'((tbl[t].n - 1) * (LAT + 1) + 1));
      check($sformatf("v%0d_ready_cycles", t), 32'(rdy), 32'(tbl[t].n));
      check($sformatf("v%0d_tag_latency", t), 32'(lat_wait), 32'(LAT));
      check($sformatf("v%0d_clr_pulses", t), 32'(clr_cnt), 32'd1);
      ack_tag();
    end

    // randomized messages, odd iterations with in_valid gaps
    for (int it = 0; it < 10; it++) begin
      logic [31:0] riv, rkey;
      int n;
      riv  = $urandom;
      rkey = $urandom;
      n    = (it == 4) ? 40 : $urandom_range(6, 1);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_msg(riv, rkey, it[0]);
      model(riv, rkey);
      check($sformatf("rnd%0d_tag", it), bus.tag, mtag);
      check($sformatf("rnd%0d_wc", it), 32'(bus.word_count), 32'(n));
      check($sformatf("rnd%0d_nwords", it), 32'(xq.size()), 32'(n));
      for (int i = 0; i < n && i < xq.size(); i++) begin
        check($sformatf("rnd%0d_x%0d", it, i), xq[i], exq[i]);
        check($sformatf("rnd%0d_r%0d", it, i), rq[i], erq[i]);
      end
      ack_tag();
    end

    // backpressure on the tag, with start pulses in DONE that must be ignored
    wq.delete(); wq.push_back(32'h100);
    run_msg(32'h5, 32'h3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.start = (k % 2 == 0);
      @(negedge clk);
      check($sformatf("bp%0d_tag_valid", k), 32'(bus.tag_valid), 32'd1);
      check($sformatf("bp%0d_tag", k), bus.tag, 32'h106);
    end
    bus.start = 1'b0;
    ack_tag();
    check("bp_tag_hold", bus.tag, 32'h106);
    check("bp_wc_hold", 32'(bus.word_count), 32'd1);
    check("bp_no_clr", 32'(bus.nmix_clr), 32'd0);
    @(negedge clk);
    check("bp_still_idle", 32'(bus.busy), 32'd0);

    // start and abort together in IDLE: start wins; then abort in WORD
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("sa_busy", 32'(bus.busy), 32'd1);
    check("sa_in_ready", 32'(bus.in_ready), 32'd1);
    check("sa_clr", 32'(bus.nmix_clr), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_word_busy", 32'(bus.busy), 32'd0);
    check("abort_word_in_ready", 32'(bus.in_ready), 32'd0);

    // abort in CALC of round 1
    bus.iv = 32'h1111; bus.key = 32'h1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h2; bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int g = 0; g < 20 && !bus.in_ready; g++) @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 32'h4; bus.in_last = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("abort_calc_r_round1", bus.nmix_r, 32'h2);
    check("abort_calc_busy_before", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_calc_busy", 32'(bus.busy), 32'd0);
    check("abort_calc_tag_valid", 32'(bus.tag_valid), 32'd0);
    check("abort_calc_in_ready", 32'(bus.in_ready), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus.tag_valid || bus.busy) seen++;
      end
      check("abort_calc_quiet", 32'(seen), 32'd0);
    end
    wq.delete(); wq.push_back(32'hAB);
    run_msg(32'h0F0F0000, 32'h10, 1'b0);
    model(32'h0F0F0000, 32'h10);
    check("after_abort_tag", bus.tag, mtag);
    check("after_abort_clr_pulses", 32'(clr_cnt), 32'd1);
    ack_tag();

    // async reset while in CALC
    bus.iv = 32'hDEAD0000; bus.key = 32'h7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h55; bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_calc_busy", 32'(bus.busy), 32'd1);
    check("rst_calc_x", bus.nmix_x, 32'hDEAD0055);
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    #3 reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_tag_valid", 32'(bus.tag_valid), 32'd0);
    wq.delete(); wq.push_back(32'h12345678);
    run_msg(32'hCAFEF00D, 32'h00010000, 1'b0);
    model(32'hCAFEF00D, 32'h00010000);
    check("post_rst_tag", bus.tag, mtag);
    ack_tag();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
